// File: rtl/dsp_slice_param.sv
// rtl/dsp_slice_param.sv - parametrised pre-add / multiply / post-add-accumulate DSP slice (optional DSP_SAT_EN saturation)
module dsp_slice_param #(
    parameter int    DATA_W     = 18,
    parameter int    ACC_W      = 48,
    parameter int    INREG      = 1,
    parameter int    MREG       = 1,
    parameter int    PREG       = 1,
    parameter string CARRYINSEL = "OPMODE5",
    parameter string B_INPUT    = "DIRECT"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CEIN,
    input  logic                  CEM,
    input  logic                  CEP,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [DATA_W-1:0]     D,
    input  logic [DATA_W-1:0]     BCIN,
    input  logic [ACC_W-1:0]      C,
    input  logic [ACC_W-1:0]      PCIN,
    input  logic [7:0]            OPMODE,
    input  logic                  CARRYIN,
    input  logic                  VALID_IN,
    output logic [DATA_W-1:0]     BCOUT,
    output logic [2*DATA_W-1:0]   M,
    output logic [ACC_W-1:0]      P,
    output logic [ACC_W-1:0]      PCOUT,
    output logic                  CARRYOUT,
    output logic                  CARRYOUTF,
    output logic                  SATFLAG,
    output logic                  VALID_OUT
);

    localparam bit USE_BCIN    = (B_INPUT == "CASCADE");
    localparam bit USE_CIN_PIN = (CARRYINSEL == "CARRYIN");

    // post-adder control bits carried alongside the product: {sub, z[1:0], x[1:0]}
    localparam int CTL_W = 5;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] b_src;
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W-1:0] d_s;
    logic [ACC_W-1:0]  c_s;
    logic [7:0]        op_s;
    logic              cin_pin_s;
    logic              v_in_s;

    assign b_src = USE_BCIN ? BCIN : B;

    if (INREG != 0) begin : g_in_reg
        // Operand/control capture; RST wins over CEIN
        always_ff @(posedge CLK) begin
            if (RST) begin
                a_s       <= '0;
                b_s       <= '0;
                d_s       <= '0;
                c_s       <= '0;
                op_s      <= '0;
                cin_pin_s <= 1'b0;
                v_in_s    <= 1'b0;
            end else if (CEIN) begin
                a_s       <= A;
                b_s       <= b_src;
                d_s       <= D;
                c_s       <= C;
                op_s      <= OPMODE;
                cin_pin_s <= CARRYIN;
                v_in_s    <= VALID_IN;
            end
        end
    end else begin : g_in_comb
        // Input stage bypassed
        always_comb begin
            a_s       = A;
            b_s       = b_src;
            d_s       = D;
            c_s       = C;
            op_s      = OPMODE;
            cin_pin_s = CARRYIN;
            v_in_s    = VALID_IN;
        end
    end

    // ------------------------------------------------------------------
    // Pre-adder, multiplier and {D,A,B} concatenation
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   pre_sum;
    logic [DATA_W-1:0]   bc;
    logic [2*DATA_W-1:0] mult;
    logic [ACC_W-1:0]    dab;
    logic                cin_sel;
    logic [CTL_W-1:0]    ctl_s;

    // Pre-adder wraps modulo 2^DATA_W; OPMODE[4] chooses what feeds the multiplier
    always_comb begin
        pre_sum = op_s[6] ? (d_s - b_s) : (d_s + b_s);
        bc      = op_s[4] ? pre_sum : b_s;
        mult    = {{DATA_W{1'b0}}, bc} * {{DATA_W{1'b0}}, a_s};
        dab     = ACC_W'({d_s, a_s, b_s});
        cin_sel = USE_CIN_PIN ? cin_pin_s : op_s[5];
        ctl_s   = {op_s[7], op_s[3:0]};
    end

    assign BCOUT = bc;

    // ------------------------------------------------------------------
    // M stage: product plus the controls/operands of the same sample, so a
    // sample's post-add always uses its own OPMODE, C and carry
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] m_s;
    logic [CTL_W-1:0]    ctl_m;
    logic [ACC_W-1:0]    c_m;
    logic [ACC_W-1:0]    dab_m;
    logic                cin_m;
    logic                v_m;

    if (MREG != 0) begin : g_m_reg
        // Multiplier register with its aligned controls
        always_ff @(posedge CLK) begin
            if (RST) begin
                m_s   <= '0;
                ctl_m <= '0;
                c_m   <= '0;
                dab_m <= '0;
                cin_m <= 1'b0;
                v_m   <= 1'b0;
            end else if (CEM) begin
                m_s   <= mult;
                ctl_m <= ctl_s;
                c_m   <= c_s;
                dab_m <= dab;
                cin_m <= cin_sel;
                v_m   <= v_in_s;
            end
        end
    end else begin : g_m_comb
        // M stage bypassed
        always_comb begin
            m_s   = mult;
            ctl_m = ctl_s;
            c_m   = c_s;
            dab_m = dab;
            cin_m = cin_sel;
            v_m   = v_in_s;
        end
    end

    assign M = m_s;

    // ------------------------------------------------------------------
    // Post-adder / accumulator
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] p_s;
    logic             co_s;
    logic             sat_s;
    logic             v_p;
    logic [ACC_W-1:0] p_fb;
    logic [ACC_W-1:0] x_mux;
    logic [ACC_W-1:0] z_mux;
    logic [ACC_W:0]   xc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] p_next;
    logic             sat_hit;

    // Without a P register the feedback would be a combinational loop, so it reads 0
    if (PREG != 0) begin : g_fb
        assign p_fb = p_s;
    end else begin : g_no_fb
        assign p_fb = '0;
    end

    // X/Z selection, ACC_W+1 bit add/subtract and optional clamp
    always_comb begin
        x_mux = '0;
        unique case (ctl_m[1:0])
            2'd0:    x_mux = '0;
            2'd1:    x_mux = ACC_W'(m_s);
            2'd2:    x_mux = p_fb;
            default: x_mux = dab_m;
        endcase
        z_mux = '0;
        unique case (ctl_m[3:2])
            2'd0:    z_mux = '0;
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = p_fb;
            default: z_mux = c_m;
        endcase
        xc  = {1'b0, x_mux} + {{ACC_W{1'b0}}, cin_m};
        sum = ctl_m[4] ? ({1'b0, z_mux} - xc) : ({1'b0, z_mux} + xc);
`ifdef DSP_SAT_EN
        // bit ACC_W is the carry on add and the borrow on subtract
        sat_hit = sum[ACC_W];
        if (sat_hit) begin
            p_next = ctl_m[4] ? '0 : '1;
        end else begin
            p_next = sum[ACC_W-1:0];
        end
`else
        sat_hit = 1'b0;
        p_next  = sum[ACC_W-1:0];
`endif
    end

    if (PREG != 0) begin : g_p_reg
        // Result register; CARRYOUT keeps the raw bit ACC_W even when clamped
        always_ff @(posedge CLK) begin
            if (RST) begin
                p_s   <= '0;
                co_s  <= 1'b0;
                sat_s <= 1'b0;
                v_p   <= 1'b0;
            end else if (CEP) begin
                p_s   <= p_next;
                co_s  <= sum[ACC_W];
                sat_s <= sat_hit;
                v_p   <= v_m;
            end
        end
    end else begin : g_p_comb
        // P stage bypassed
        always_comb begin
            p_s   = p_next;
            co_s  = sum[ACC_W];
            sat_s = sat_hit;
            v_p   = v_m;
        end
    end

    assign P         = p_s;
    assign PCOUT     = p_s;
    assign CARRYOUT  = co_s;
    assign CARRYOUTF = co_s;
    assign SATFLAG   = sat_s;
    assign VALID_OUT = v_p;

endmodule

// File: doc/dsp_slice_param.md
# dsp_slice_param

- Parametrised successor to the fixed 18x18/48-bit DSP slice.
- Datapath: pre-adder/subtractor, unsigned multiplier, post-adder/subtractor/accumulator with cascade ports.
- Operand widths, pipeline depth and carry-in source are parameters.
- New over the fixed slice: a valid pipeline that tracks latency and clock enables, plus optional post-adder saturation.
- Used as the MAC/accumulate primitive in filter and correlator datapaths.

## Interface
Parameters:
- DATA_W, 18, width of A, B, D, BCIN, BCOUT; M is 2*DATA_W
- ACC_W, 48, width of C, PCIN, P, PCOUT
- INREG, 1, 0/1: register stage on A, B, C, D, OPMODE, CARRYIN
- MREG, 1, 0/1: register on multiplier output
- PREG, 1, 0/1: register on post-adder output and CARRYOUT
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" or "CARRYIN"
- B_INPUT, "DIRECT", B operand source: "DIRECT" (B) or "CASCADE" (BCIN)

Ports (clocking and reset): one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all registers on rising edge
- RST  in  1  synchronous active-high reset of every register
- CEIN  in  1  enable, input stage
- CEM  in  1  enable, M stage
- CEP  in  1  enable, P stage
- A, B, D, BCIN  in  DATA_W  operands
- C, PCIN  in  ACC_W  post-adder operands
- OPMODE  in  8  mode word
- CARRYIN  in  1  external carry
- VALID_IN  in  1  sample qualifier
- BCOUT  out  DATA_W  B after the pre-adder
- M  out  2*DATA_W  product
- P, PCOUT  out  ACC_W  result; PCOUT == P
- CARRYOUT, CARRYOUTF  out  1  post-adder bit ACC_W; identical
- SATFLAG  out  1  saturation occurred; constant 0 without the macro
- VALID_OUT  out  1  VALID_IN delayed by LATENCY = INREG+MREG+PREG

## Operation
OPMODE fields:
- [1:0]: X mux: 0, M zero-extended, P, or low ACC_W bits of {D,A,B} (zero-extended if narrower).
- [3:2]: Z mux: 0, PCIN, P, C.
- [4]: 1 routes the pre-adder result to BCOUT and the multiplier; 0 routes B.
- [5]: carry bit when CARRYINSEL="OPMODE5".
- [6]: pre-adder mode; 0 = D+B, 1 = D−B, modulo 2^DATA_W.
- [7]: post-adder mode; 0 = Z+(X+CIN), 1 = Z−(X+CIN).

Arithmetic:
- M = BCOUT × A, unsigned.
- The post-adder computes ACC_W+1 bits. P takes the low ACC_W bits; CARRYOUT takes bit ACC_W.
- With PREG=0, the P selections on X and Z yield 0 (no combinational loop).
- A stage parameter of 0 makes that stage combinational pass-through.

## Timing
- Reset: with all REG parameters at 1, RST clears P, PCOUT, M, BCOUT, CARRYOUT, CARRYOUTF, SATFLAG and VALID_OUT to 0 on the next edge.
- Reset-stage registers: the stages to which RST applies clear to 0; RST overrides CE.
- Latency, defaults: BCOUT 1 cycle, M 2, P/CARRYOUT 3, VALID_OUT 3.
- CE low on a stage: that stage's data and valid bit hold. Downstream stages keep sampling the held value.
- Valid bits travel with their stage enables, so VALID_OUT stays aligned with P under any CE pattern.
- Accumulate (Z=P): uses the P register value from the previous cycle, giving one accumulation per enabled P cycle.
- Reset mid-accumulation: P returns to 0 and the accumulation restarts from the next input.

## Configuration
DSP_SAT_EN defined:
- Add overflow (carry set, OPMODE[7]=0) clamps P to all-ones.
- Subtract underflow (borrow set, OPMODE[7]=1) clamps P to 0.
- SATFLAG is registered with P. CARRYOUT still reports the raw bit ACC_W.

DSP_SAT_EN undefined:
- P wraps modulo 2^ACC_W.
- SATFLAG is tied 0.

## Test plan
Default parameters in every scenario.
- Reset: random inputs, all CE=1, RST=1 for 2 cycles → every output 0, VALID_OUT 0.
- Path: OPMODE=8'b11011101, A=20, B=10, C=350, D=25, VALID_IN pulse.
  - After 3 cycles: BCOUT=0xF, M=0x12C, P=PCOUT=0x32, CARRYOUT=0.
  - VALID_OUT is high exactly 3 cycles after the VALID_IN pulse.
- Accumulate: OPMODE=8'b00001001, A=3, B=4 held, RST released → P=12, 24, 36 on successive cycles.
  - CEP=0 for 2 cycles freezes P and VALID_OUT.
  - RST while CEP=0 still clears them.
- Underflow: OPMODE=8'b10000001, A=1, B=1.
  - No macro: P=0xFFFFFFFFFFFF, CARRYOUT=1.
  - DSP_SAT_EN: P=0, SATFLAG=1.
- Overflow: OPMODE=8'b00001101, C=0xFFFFFFFFFFFF, A=1, B=1.
  - No macro: P=0, CARRYOUT=1.
  - DSP_SAT_EN: P=0xFFFFFFFFFFFF, SATFLAG=1.
- Cascade/carry: B_INPUT="CASCADE", CARRYINSEL="CARRYIN", OPMODE=8'b00000101 (Z=PCIN), PCIN=3000, BCIN=2, A=5, CARRYIN=1 → M=10, P=3011.
